// File: rtl/fetch_arb_if.sv
// Fetch request channel: requester-to-arbiter and arbiter-to-engine links share this bundle.
interface fetch_arb_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned TagWidth  = 2
);
    logic                 req;
    logic [1:0]           cmd;
    logic [TagWidth-1:0]  tag;
    logic [AddrWidth-1:0] addr;
    logic [AddrWidth-1:0] addr_pre;
    logic                 gnt;
    logic                 done;

    modport master (
        output req,
        output cmd,
        output tag,
        output addr,
        output addr_pre,
        input  gnt,
        input  done
    );

    modport slave (
        input  req,
        input  cmd,
        input  tag,
        input  addr,
        input  addr_pre,
        output gnt,
        output done
    );
endinterface

// File: rtl/fetch_arb.sv
// Round-robin arbiter between the read and write controllers for the shared line-fetch
// engine; keeps one fetch in flight and routes grant/done back to its owner.
module fetch_arb #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned ListDepth     = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk,
    input  logic        rst,
    fetch_arb_if.slave  rd_fetch,
    fetch_arb_if.slave  wr_fetch,
    fetch_arb_if.master mem_fetch,
    output logic        fetch_busy_o,
    output logic        fetch_owner_o,
    output logic        fetch_timeout_o
);
    localparam int unsigned TagWidth = (ListDepth > 1) ? $clog2(ListDepth) : 1;
    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone
    } state_e;

    state_e state_q, state_d;

    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;
    logic [1:0]           cmd_q, cmd_d;
    logic [TagWidth-1:0]  tag_q, tag_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] addr_pre_q, addr_pre_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic any_req;
    logic win_wr;

    assign any_req = rd_fetch.req | wr_fetch.req;
    // On a tie the port that did not own the previous fetch wins.
    assign win_wr  = wr_fetch.req & (~rd_fetch.req | ~last_owner_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem_fetch.gnt) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (mem_fetch.done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode; gnt and done are routed combinationally to the owner only.
    always_comb begin
        mem_fetch.req = 1'b0;
        rd_fetch.gnt  = 1'b0;
        wr_fetch.gnt  = 1'b0;
        rd_fetch.done = 1'b0;
        wr_fetch.done = 1'b0;
        fetch_busy_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                fetch_busy_o = 1'b0;
            end
            StIssue: begin
                mem_fetch.req = 1'b1;
                fetch_busy_o  = 1'b1;
                rd_fetch.gnt  = mem_fetch.gnt & ~owner_q;
                wr_fetch.gnt  = mem_fetch.gnt & owner_q;
            end
            StWaitDone: begin
                fetch_busy_o  = 1'b1;
                rd_fetch.done = mem_fetch.done & ~owner_q;
                wr_fetch.done = mem_fetch.done & owner_q;
            end
            default: begin
                fetch_busy_o = 1'b0;
            end
        endcase
    end

    assign fetch_owner_o      = owner_q;
    assign fetch_timeout_o    = timeout_q;
    assign mem_fetch.cmd      = cmd_q;
    assign mem_fetch.tag      = tag_q;
    assign mem_fetch.addr     = addr_q;
    assign mem_fetch.addr_pre = addr_pre_q;

    // Payload capture, ownership history and watchdog next-state
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_d        = cmd_q;
        tag_d        = tag_q;
        addr_d       = addr_q;
        addr_pre_d   = addr_pre_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;

        if (state_q == StIdle && any_req) begin
            owner_d = win_wr;
            if (win_wr) begin
                cmd_d      = wr_fetch.cmd;
                tag_d      = wr_fetch.tag;
                addr_d     = wr_fetch.addr;
                addr_pre_d = wr_fetch.addr_pre;
            end else begin
                cmd_d      = rd_fetch.cmd;
                tag_d      = rd_fetch.tag;
                addr_d     = rd_fetch.addr;
                addr_pre_d = rd_fetch.addr_pre;
            end
        end

        if (state_q == StWaitDone && mem_fetch.done) begin
            last_owner_d = owner_q;
        end

        if (state_q == StIdle) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Sticky: only reset clears it, and the fetch itself carries on.
            if (cnt_q == CntMax) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cmd_q        <= '0;
            tag_q        <= '0;
            addr_q       <= '0;
            addr_pre_q   <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_q        <= cmd_d;
            tag_q        <= tag_d;
            addr_q       <= addr_d;
            addr_pre_q   <= addr_pre_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end
endmodule

// File: tb/tb_fetch_arb.sv
// Scoreboard bench for fetch_arb: expected fetches are queued as requests are driven and
// compared when the arbiter presents them to the engine.
module tb_fetch_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned LD = 4;
    localparam int unsigned TW = 2;
    localparam int unsigned TO = 8;

    typedef struct packed {
        logic          owner;
        logic [1:0]    cmd;
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [AW-1:0] addr_pre;
    } fetch_t;

    logic clk = 1'b0;
    logic rst;
    logic busy, owner, timeout;
    logic last_m;
    int   n_checks = 0;
    int   n_fail = 0;
    fetch_t exp_q[$];

    always #5 clk = ~clk;

    fetch_arb_if #(.AddrWidth(AW), .TagWidth(TW)) rd_if ();
    fetch_arb_if #(.AddrWidth(AW), .TagWidth(TW)) wr_if ();
    fetch_arb_if #(.AddrWidth(AW), .TagWidth(TW)) mem_if ();

    fetch_arb #(
        .AddrWidth    (AW),
        .ListDepth    (LD),
        .TimeoutCycles(TO)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .rd_fetch       (rd_if),
        .wr_fetch       (wr_if),
        .mem_fetch      (mem_if),
        .fetch_busy_o   (busy),
        .fetch_owner_o  (owner),
        .fetch_timeout_o(timeout)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_port(input bit wr, input logic [1:0] cmd, input logic [TW-1:0] tag,
                            input logic [AW-1:0] addr, input logic [AW-1:0] pre);
        if (wr) begin
            wr_if.cmd = cmd; wr_if.tag = tag; wr_if.addr = addr; wr_if.addr_pre = pre;
        end else begin
            rd_if.cmd = cmd; rd_if.tag = tag; rd_if.addr = addr; rd_if.addr_pre = pre;
        end
    endtask

    task automatic push_expected(input logic own);
        fetch_t e;
        e.owner = own;
        if (own) begin
            e.cmd = wr_if.cmd; e.tag = wr_if.tag; e.addr = wr_if.addr; e.addr_pre = wr_if.addr_pre;
        end else begin
            e.cmd = rd_if.cmd; e.tag = rd_if.tag; e.addr = rd_if.addr; e.addr_pre = rd_if.addr_pre;
        end
        exp_q.push_back(e);
    endtask

    task automatic compare_issue();
        fetch_t e;
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("issue_busy", busy, 1);
            check_eq("issue_owner", owner, e.owner);
            check_eq("issue_cmd", mem_if.cmd, e.cmd);
            check_eq("issue_tag", mem_if.tag, e.tag);
            check_eq("issue_addr", mem_if.addr, e.addr);
            check_eq("issue_addr_pre", mem_if.addr_pre, e.addr_pre);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_mem_req"}, mem_if.req, 0);
        check_eq({name, "_payload"}, {mem_if.cmd, mem_if.tag, mem_if.addr}, 0);
        check_eq({name, "_addr_pre"}, mem_if.addr_pre, 0);
        check_eq({name, "_gnt_done"}, {rd_if.gnt, wr_if.gnt, rd_if.done, wr_if.done}, 0);
        check_eq({name, "_status"}, {busy, owner, timeout}, 0);
    endtask

    // Starts in the drive phase of a cycle where the DUT is idle with requests driven.
    // Returns in the drive phase of the cycle after done.
    task automatic run_fetch(input int gd, input int dd, input bit hold, input bit raise_other);
        logic own;
        int   lat;
        own = (rd_if.req && wr_if.req) ? ~last_m : wr_if.req;
        push_expected(own);
        lat = 0;
        smp();
        while (!mem_if.req && lat < 20) begin
            cyc();
            smp();
            lat++;
        end
        check_eq("issue_req", mem_if.req, 1);
        check_eq("issue_latency", 64'(lat), 1);
        compare_issue();
        repeat (gd) begin
            cyc();
            smp();
            check_eq("early_gnt", {rd_if.gnt, wr_if.gnt}, 0);
        end
        cyc();
        mem_if.gnt = 1'b1;
        smp();
        check_eq("owner_gnt", own ? wr_if.gnt : rd_if.gnt, 1);
        check_eq("other_gnt", own ? rd_if.gnt : wr_if.gnt, 0);
        cyc();
        mem_if.gnt = 1'b0;
        if (!hold) begin
            if (own) wr_if.req = 1'b0; else rd_if.req = 1'b0;
        end
        if (raise_other) begin
            if (own) rd_if.req = 1'b1; else wr_if.req = 1'b1;
        end
        repeat (dd - 1) begin
            smp();
            check_eq("wait_req", mem_if.req, 0);
            check_eq("wait_gnt_done", {rd_if.gnt, wr_if.gnt, rd_if.done, wr_if.done}, 0);
            cyc();
        end
        mem_if.done = 1'b1;
        smp();
        check_eq("owner_done", own ? wr_if.done : rd_if.done, 1);
        check_eq("other_done", own ? rd_if.done : wr_if.done, 0);
        cyc();
        mem_if.done = 1'b0;
        last_m = own;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        rd_if.req = 1'b0;
        wr_if.req = 1'b0;
        mem_if.gnt = 1'b0;
        mem_if.done = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        last_m = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1;
        rd_if.req = 1'b0;
        wr_if.req = 1'b0;
        mem_if.gnt = 1'b0;
        mem_if.done = 1'b0;
        set_port(1'b0, 2'b00, '0, '0, '0);
        set_port(1'b1, 2'b00, '0, '0, '0);
        #1;
        check_all_zero("reset");
        reset_dut();

        // Single read: issue in cycle 1, gnt cycle 3, done cycle 7, idle cycle 8.
        set_port(1'b0, 2'b01, 2'd2, 32'h100, 32'h0);
        rd_if.req = 1'b1;
        run_fetch(1, 4, 1'b0, 1'b0);
        smp();
        check_eq("single_idle", {busy, mem_if.req}, 0);
        check_eq("single_timeout", timeout, 0);

        // Round-robin ties starting from reset: read, write, read.
        reset_dut();
        set_port(1'b0, 2'b01, 2'd1, 32'h0000_1240, 32'h0000_0a40);
        set_port(1'b1, 2'b10, 2'd3, 32'h8000_0080, 32'h7fff_ff80);
        rd_if.req = 1'b1;
        wr_if.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_fetch(i, 1 + i, 1'b1, 1'b0);
        end
        rd_if.req = 1'b0;
        wr_if.req = 1'b0;
        check_eq("rr_last", last_m, 0);

        // Busy collision: write raised while the read waits for done.
        reset_dut();
        set_port(1'b0, 2'b01, 2'd0, 32'h0000_2000, 32'h0);
        set_port(1'b1, 2'b10, 2'd2, 32'h0000_3000, 32'h0000_4000);
        rd_if.req = 1'b1;
        run_fetch(0, 3, 1'b0, 1'b1);
        run_fetch(1, 2, 1'b0, 1'b0);

        // Spurious strobes and simultaneous gnt/done in ISSUE.
        reset_dut();
        set_port(1'b0, 2'b10, 2'd3, 32'h0000_5540, 32'h0000_6640);
        rd_if.req = 1'b1;
        push_expected(1'b0);
        cyc();
        smp();
        check_eq("spur_issue_req", mem_if.req, 1);
        compare_issue();
        cyc();
        mem_if.done = 1'b1;
        smp();
        check_eq("spur_done_in_issue", {rd_if.gnt, wr_if.gnt, rd_if.done, wr_if.done}, 0);
        cyc();
        mem_if.gnt = 1'b1;
        smp();
        check_eq("both_strobes_gnt", {rd_if.gnt, rd_if.done}, 2'b10);
        cyc();
        mem_if.gnt = 1'b0;
        mem_if.done = 1'b0;
        rd_if.req = 1'b0;
        smp();
        check_eq("spur_wait_state", {busy, mem_if.req}, 2'b10);
        cyc();
        mem_if.gnt = 1'b1;
        smp();
        check_eq("spur_gnt_in_wait", {rd_if.gnt, wr_if.gnt, rd_if.done, wr_if.done}, 0);
        check_eq("spur_gnt_state", {busy, mem_if.req}, 2'b10);
        cyc();
        mem_if.gnt = 1'b0;
        mem_if.done = 1'b1;
        smp();
        check_eq("spur_real_done", rd_if.done, 1);
        cyc();
        mem_if.done = 1'b0;
        smp();
        check_eq("spur_idle", {busy, mem_if.req, timeout}, 0);

        // Watchdog: gnt withheld, flag rises after the 8th busy cycle and is sticky.
        reset_dut();
        set_port(1'b0, 2'b01, 2'd1, 32'h0000_0040, 32'h0);
        rd_if.req = 1'b1;
        push_expected(1'b0);
        for (int i = 0; i <= 10; i++) begin
            smp();
            check_eq($sformatf("wdog_c%0d", i), timeout, 64'(i >= 9));
            if (i == 1) compare_issue();
            cyc();
        end
        mem_if.gnt = 1'b1;
        smp();
        check_eq("wdog_gnt", rd_if.gnt, 1);
        cyc();
        mem_if.gnt = 1'b0;
        rd_if.req = 1'b0;
        cyc();
        mem_if.done = 1'b1;
        smp();
        check_eq("wdog_done", rd_if.done, 1);
        cyc();
        mem_if.done = 1'b0;
        cyc();
        smp();
        check_eq("wdog_sticky", {timeout, busy}, 2'b10);
        cyc();
        rst = 1'b1;
        #1;
        check_eq("wdog_rst_clear", timeout, 0);

        // Reset mid-fetch with a write owning the engine and done pending.
        reset_dut();
        set_port(1'b1, 2'b10, 2'd2, 32'h0000_9000, 32'h0000_a000);
        wr_if.req = 1'b1;
        push_expected(1'b1);
        cyc();
        smp();
        compare_issue();
        cyc();
        mem_if.gnt = 1'b1;
        smp();
        check_eq("mid_gnt", wr_if.gnt, 1);
        cyc();
        mem_if.gnt = 1'b0;
        wr_if.req = 1'b0;
        mem_if.done = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        mem_if.done = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        last_m = 1'b1;
        set_port(1'b0, 2'b01, 2'd1, 32'h0000_b000, 32'h0);
        rd_if.req = 1'b1;
        wr_if.req = 1'b1;
        run_fetch(0, 1, 1'b0, 1'b0);
        check_eq("post_rst_read_first", last_m, 0);
        run_fetch(0, 2, 1'b0, 1'b0);

        check_eq("sb_drain", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
